// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM32 control unit: Moore main FSM, instruction field decode,
// NZCV flag register and condition check gating every architectural write.
module arm_multicycle_controller #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic [3:0]  State,
  output logic        Illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  state_t      state, next_state;
  logic [3:0]  flags;
  logic        cond_ex, cond_ex_reg;

  logic [1:0]  op;
  logic [5:0]  funct;
  logic        i_bit, s_bit, l_bit;
  logic [3:0]  cmd, rd, cond;
  logic        legal_cmd, illegal_enc, flag_update;
  logic [1:0]  alu_dp;
  logic        unused_instr_bits;

  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign i_bit = funct[5];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];
  assign l_bit = funct[0];
  assign rd    = Instr[15:12];
  assign cond  = Instr[31:28];
  assign unused_instr_bits = ^{Instr[19:16], Instr[11:0]};

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign State  = state;

  always_comb begin
    legal_cmd = 1'b1;
    alu_dp    = 2'b00;
    unique case (cmd)
      CMD_ADD: alu_dp = 2'b00;
      CMD_SUB: alu_dp = 2'b01;
      CMD_AND: alu_dp = 2'b10;
      CMD_ORR: alu_dp = 2'b11;
      default: legal_cmd = 1'b0;
    endcase
  end

  // Command legality only constrains data-processing; memory/branch funct bits carry other fields.
  assign illegal_enc = (op == 2'b11) || ((op == 2'b00) && !legal_cmd);

  // flags = {N,Z,C,V}
  always_comb begin
    cond_ex = 1'b0;
    unique case (cond)
      4'h0: cond_ex = flags[2];
      4'h1: cond_ex = !flags[2];
      4'h2: cond_ex = flags[1];
      4'h3: cond_ex = !flags[1];
      4'h4: cond_ex = flags[3];
      4'h5: cond_ex = !flags[3];
      4'h6: cond_ex = flags[0];
      4'h7: cond_ex = !flags[0];
      4'h8: cond_ex = flags[1] && !flags[2];
      4'h9: cond_ex = !flags[1] || flags[2];
      4'hA: cond_ex = (flags[3] == flags[0]);
      4'hB: cond_ex = (flags[3] != flags[0]);
      4'hC: cond_ex = !flags[2] && (flags[3] == flags[0]);
      4'hD: cond_ex = flags[2] || (flags[3] != flags[0]);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign flag_update = ((state == S_EXECUTER) || (state == S_EXECUTEI)) && s_bit && cond_ex_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      cond_ex_reg <= 1'b0;
      flags       <= FLAGS_RESET;
    end else begin
      state <= next_state;
      if (state == S_DECODE)
        cond_ex_reg <= cond_ex;
      if (flag_update) begin
        if ((cmd == CMD_ADD) || (cmd == CMD_SUB))
          flags <= ALUFlags;
        else
          flags[3:2] <= ALUFlags[3:2];
      end
    end
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    Illegal    = 1'b0;
    unique case (state)
      S_FETCH: begin
        IRWrite    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (illegal_enc) begin
          Illegal    = 1'b1;
          next_state = S_FETCH;
        end else begin
          case (op)
            2'b00:   next_state = i_bit ? S_EXECUTEI : S_EXECUTER;
            2'b01:   next_state = S_MEMADR;
            default: next_state = S_BRANCH;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        next_state = l_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc     = 1'b1;
        next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = cond_ex_reg;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        MemWrite   = cond_ex_reg;
        next_state = S_FETCH;
      end
      S_EXECUTER: begin
        ALUControl = alu_dp;
        next_state = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dp;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = cond_ex_reg;
        PCWrite    = cond_ex_reg && (rd == 4'd15);
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        PCWrite    = cond_ex_reg;
        next_state = S_FETCH;
      end
      default: next_state = S_FETCH;
    endcase
    // Reset forces enables off combinationally so a pending write dies the moment reset asserts.
    if (!reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      Illegal  = 1'b0;
    end
  end

endmodule

// File: doc/arm_multicycle_controller.md
Name: arm_multicycle_controller

Overview:
- Control unit for the multicycle ARM32 core variant; replaces the single-cycle decoder.
- A Moore main FSM walks each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Decodes ALU operation, immediate and register-source selects from the latched instruction word.
- Owns the NZCV flag register and condition check, and gates every architectural write with the registered condition result.

Parameters:
FLAGS_RESET, 4'b0000, reset value of the internal {N,Z,C,V} flag register

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
Instr  input  32  instruction register output; stable from DECODE until next FETCH
ALUFlags  input  4  ALU {N,Z,C,V} of the current cycle's operation
PCWrite  output  1  PC register load enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register load enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  00 = ALUOut reg, 01 = Data reg, 10 = ALUResult
ALUSrcA  output  1  0 = register A, 1 = PC
ALUSrcB  output  2  00 = register WriteData, 01 = ExtImm, 10 = constant 4
ImmSrc  output  2  extender mode, equals Instr[27:26]
RegSrc  output  2  [0] = read PC as Rn (op==10), [1] = read Rd as Rm (op==01)
ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR
State  output  4  current FSM state encoding (debug/verification)
Illegal  output  1  one-cycle pulse in DECODE on an unsupported encoding

Behaviour:
- Reset (reset==0, asynchronous):
  - State = FETCH; flags = FLAGS_RESET; CondExReg = 0.
  - All enables (PCWrite, MemWrite, IRWrite, RegWrite, Illegal) are 0 while reset is held.
  - The first rising edge after release performs FETCH.
- Fields: op = Instr[27:26], funct = Instr[25:20], I = funct[5], cmd = funct[4:1], S = funct[0], L = funct[0] for memory ops, Rd = Instr[15:12].
- Transitions:
  - FETCH -> DECODE.
  - DECODE, op 00, I=0 -> EXECUTER.
  - DECODE, op 00, I=1 -> EXECUTEI.
  - DECODE, op 01 -> MEMADR.
  - DECODE, op 10 -> BRANCH.
  - DECODE, op 11 or cmd not in {0100, 0010, 0000, 1100} -> FETCH, with Illegal = 1 for that cycle and no writes.
  - MEMADR -> MEMRD if L=1, otherwise MEMWR.
  - MEMRD -> MEMWB.
  - EXECUTER, EXECUTEI -> ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
- Latency: data-processing 4 cycles, STR 4, LDR 5, B 3, illegal 2.
- State outputs (unlisted outputs are 0 / don't-care-zero):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (PC+8 for branch base).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondExReg.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemWrite=CondExReg.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUControl from cmd.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUControl from cmd.
  - ALUWB: ResultSrc=00, RegWrite=CondExReg; PCWrite=CondExReg when Rd==15.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExReg.
- ImmSrc and RegSrc are combinational from Instr in every state.
- Condition check:
  - CondEx is evaluated from Instr[31:28] and the flag register, using full ARM semantics for EQ..AL; code 1111 is treated as false.
  - CondEx is latched into CondExReg on the DECODE -> next edge.
- Flags:
  - Updated on the EXECUTER/EXECUTEI exit edge only when S=1 and CondExReg=1.
  - ADD/SUB write all of NZCV; AND/ORR write N,Z only, preserving C,V.
  - The condition is never re-evaluated against flags written by the same instruction.
- reset asserted mid-instruction: any pending write is abandoned immediately; the instruction restarts from FETCH.

Test Plan:
- Hold reset low 3 cycles, then release -> State=FETCH, PCWrite=1, IRWrite=1 on first edge; flags=0000.
- ADD R1,R2,#5 (E2821005) -> FETCH, DECODE, EXECUTEI (ALUControl=00, ALUSrcB=01), ALUWB (RegWrite=1); 4 cycles; flags unchanged (S=0).
- SUBS R3,R3,R3 (E0533003) -> EXECUTER ALUControl=01; flags capture ALUFlags=0100 (Z=1); next BEQ (0A000002) -> BRANCH with PCWrite=1.
- With Z=0: MOVEQ-style ADDEQ R0,R0,#1 (02800001) -> ALUWB has RegWrite=0; LDR (E5910000) -> 5 cycles with MEMRD AdrSrc=1 and MEMWB RegWrite=1; STR (E5810000) -> MEMWR MemWrite=1.
- Instr=EC000000 (op 11) -> DECODE asserts Illegal=1 for one cycle, returns to FETCH, no RegWrite/MemWrite.
- Drive reset low during MEMWR of STR -> MemWrite drops to 0 at once, State=FETCH; after release the STR re-executes from FETCH.
